rr_mux_n: RTL and testbench

RR_MUX_N -- requirements
Module: rr_mux_n

---
 rtl/rr_mux_n.sv | 122 ++++++++++++
 tb/tb_rr_mux_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux_n.sv
// N-channel arbitrating multiplexer with a registered output stage.
// Grants by fixed priority, round robin from a rotating pointer, or a forced channel index.
module rr_mux_n #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic [SEL_W-1:0]          y_ch
);

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SEL_W-1:0] y_ch_q, y_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] grant_idx_s;
    logic             grant_any_s;
    logic             load_en_s;
    logic             accept_s;
    logic [WIDTH-1:0] sel_data_s;
    int               rr_idx_s;

    assign load_en_s = !y_valid_q || y_ready;
    assign accept_s  = grant_any_s && load_en_s;

    // Grant decision: depends only on requests, mode, sel and the round-robin pointer.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = '0;
        rr_idx_s    = 0;
        case (mode)
            2'd1: begin
                // Walk upward from the pointer with wrap; the first requester wins.
                for (int k = 0; k < CHANNELS; k++) begin
                    rr_idx_s    = 32'(rr_ptr_q) + k;
                    rr_idx_s    = (rr_idx_s >= CHANNELS) ? rr_idx_s - CHANNELS : rr_idx_s;
                    grant_idx_s = (!grant_any_s && in_valid[rr_idx_s]) ? SEL_W'(rr_idx_s) : grant_idx_s;
                    grant_any_s = grant_any_s | in_valid[rr_idx_s];
                end
            end
            2'd2: begin
                grant_any_s = (32'(sel) < CHANNELS) && in_valid[sel];
                grant_idx_s = sel;
            end
            default: begin
                // Descending scan so the lowest-index requester is left standing.
                for (int k = CHANNELS - 1; k >= 0; k--) begin
                    grant_idx_s = in_valid[k] ? SEL_W'(k) : grant_idx_s;
                    grant_any_s = grant_any_s | in_valid[k];
                end
            end
        endcase
    end

    // One-hot accept toward the granted channel, suppressed under backpressure and reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = rst_n & load_en_s & grant_any_s & (grant_idx_s == SEL_W'(i));
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_data_s = (grant_idx_s == SEL_W'(i)) ? d[i*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_ch_d    = y_ch_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept_s) begin
            y_d       = sel_data_s;
            y_ch_d    = grant_idx_s;
            y_valid_d = 1'b1;
        end else if (load_en_s) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
        if (accept_s && (mode == 2'd1)) begin
            rr_ptr_d = (grant_idx_s == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx_s + SEL_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ch_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_ch_q    <= y_ch_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_ch    = y_ch_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: a vector table for single-cycle behaviour plus
// hand-written sequences for wrap-around, backpressure and mid-transfer reset.
module tb_rr_mux_n;

    localparam int W = 16;
    localparam int C = 8;
    localparam int S = 3;

    logic           clk;
    logic           rst_n;
    logic [C*W-1:0] d;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic [1:0]     mode;
    logic [S-1:0]   sel;
    logic [W-1:0]   y;
    logic           y_valid;
    logic           y_ready;
    logic [S-1:0]   y_ch;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [1:0]   mode;
        logic [S-1:0] sel;
        logic [C-1:0] iv;
        logic         yr;
        logic [C-1:0] ir;
        logic         yv;
        logic [W-1:0] y;
        logic [S-1:0] ych;
    } vec_t;

    vec_t tbl [17];

    rr_mux_n #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_ch     (y_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string nm, input logic yv, input logic [W-1:0] yy, input logic [S-1:0] ych);
        check({nm, ".y_valid"}, 32'(y_valid), 32'(yv));
        check({nm, ".y"},       32'(y),       32'(yy));
        check({nm, ".y_ch"},    32'(y_ch),    32'(ych));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        // ch7..ch0
        d = {16'd88, 16'd77, 16'd66, 16'd55, 16'd33, 16'd24, 16'd18, 16'd13};

        tbl[0]  = '{2'd2, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 16'd13, 3'd0};
        tbl[1]  = '{2'd2, 3'd1, 8'hFF, 1'b1, 8'h02, 1'b1, 16'd18, 3'd1};
        tbl[2]  = '{2'd2, 3'd2, 8'hFF, 1'b1, 8'h04, 1'b1, 16'd24, 3'd2};
        tbl[3]  = '{2'd2, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b1, 16'd33, 3'd3};
        tbl[4]  = '{2'd2, 3'd4, 8'hFF, 1'b1, 8'h10, 1'b1, 16'd55, 3'd4};
        tbl[5]  = '{2'd2, 3'd5, 8'hFF, 1'b1, 8'h20, 1'b1, 16'd66, 3'd5};
        tbl[6]  = '{2'd2, 3'd6, 8'hFF, 1'b1, 8'h40, 1'b1, 16'd77, 3'd6};
        tbl[7]  = '{2'd2, 3'd7, 8'hFF, 1'b1, 8'h80, 1'b1, 16'd88, 3'd7};
        tbl[8]  = '{2'd0, 3'd0, 8'hA4, 1'b1, 8'h04, 1'b1, 16'd24, 3'd2};
        tbl[9]  = '{2'd2, 3'd3, 8'h00, 1'b1, 8'h00, 1'b0, 16'd24, 3'd2};
        tbl[10] = '{2'd3, 3'd0, 8'h30, 1'b1, 8'h10, 1'b1, 16'd55, 3'd4};
        tbl[11] = '{2'd0, 3'd0, 8'h30, 1'b0, 8'h00, 1'b1, 16'd55, 3'd4};
        tbl[12] = '{2'd1, 3'd0, 8'h60, 1'b1, 8'h20, 1'b1, 16'd66, 3'd5};
        tbl[13] = '{2'd1, 3'd0, 8'h21, 1'b1, 8'h01, 1'b1, 16'd13, 3'd0};
        tbl[14] = '{2'd2, 3'd6, 8'h40, 1'b0, 8'h00, 1'b1, 16'd13, 3'd0};
        tbl[15] = '{2'd2, 3'd6, 8'h40, 1'b1, 8'h40, 1'b1, 16'd77, 3'd6};
        tbl[16] = '{2'd1, 3'd0, 8'h03, 1'b1, 8'h02, 1'b1, 16'd18, 3'd1};

        // Reset state with requests present
        rst_n    = 1'b0;
        mode     = 2'd1;
        sel      = 3'd0;
        in_valid = 8'hFF;
        y_ready  = 1'b1;
        #12;
        check_out("reset", 1'b0, 16'd0, 3'd0);
        check("reset.in_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            mode     = tbl[i].mode;
            sel      = tbl[i].sel;
            in_valid = tbl[i].iv;
            y_ready  = tbl[i].yr;
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            step();
            check_out($sformatf("vec%0d", i), tbl[i].yv, tbl[i].y, tbl[i].ych);
        end

        // Round-robin wrap from a fresh pointer
        rst_n = 1'b0;
        #2;
        rst_n    = 1'b1;
        mode     = 2'd1;
        in_valid = 8'hFF;
        y_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("rr%0d.y_ch", i), 32'(y_ch), 32'(i % 8));
            check($sformatf("rr%0d.y_valid", i), 32'(y_valid), 32'd1);
        end

        // Pointer is now 2; load ch4, then stall three cycles
        in_valid = 8'h10;
        step();
        check_out("bp_load", 1'b1, 16'd55, 3'd4);
        in_valid = 8'hFF;
        y_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
            step();
            check_out($sformatf("bp%0d", i), 1'b1, 16'd55, 3'd4);
        end
        y_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(in_ready), 32'h20);
        step();
        check_out("bp_release", 1'b1, 16'd66, 3'd5);

        // Half-cycle reset pulse while holding a word
        #1;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 16'd0, 3'd0);
        check("midrst.in_ready", 32'(in_ready), 32'h0);
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'h01);
        step();
        check_out("post_rst", 1'b1, 16'd13, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
